// File: rtl/sram_burst_pkg.sv
// Shared constants, state encoding and helpers for the SRAM burst master.
package sram_burst_pkg;

  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 8;
  localparam int TMO_DEF = 16;
  localparam int LEN_W   = 4;
  localparam int BEAT_W  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    RD_OUT  = 3'd5,
    FIN     = 3'd6
  } state_t;

  // req_len encodes beats minus one; widen before adding so 15 becomes 16.
  function automatic logic [BEAT_W-1:0] beat_count(input logic [LEN_W-1:0] len);
    return {1'b0, len} + BEAT_W'(1);
  endfunction

endpackage

// File: rtl/sram_burst_master_if.sv
// Burst request, write/read data streams, controller command and status signals.
interface sram_burst_master_if
  import sram_burst_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic             req_valid;
  logic             req_ready;
  logic             req_rw;
  logic [AW-1:0]    req_addr;
  logic [LEN_W-1:0] req_len;

  logic [DW-1:0]    wr_data;
  logic             wr_valid;
  logic             wr_ready;

  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             rd_ready;

  logic             ctrl_start;
  logic             ctrl_rw;
  logic [AW-1:0]    ctrl_addr;
  logic [DW-1:0]    ctrl_wdata;
  logic             ctrl_ready;
  logic [DW-1:0]    ctrl_rdata;

  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  req_valid, req_rw, req_addr, req_len,
    input  wr_data, wr_valid, rd_ready, ctrl_ready, ctrl_rdata,
    output req_ready, wr_ready, rd_data, rd_valid,
    output ctrl_start, ctrl_rw, ctrl_addr, ctrl_wdata,
    output busy, done, err
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_len,
    output wr_data, wr_valid, rd_ready, ctrl_ready, ctrl_rdata,
    input  req_ready, wr_ready, rd_data, rd_valid,
    input  ctrl_start, ctrl_rw, ctrl_addr, ctrl_wdata,
    input  busy, done, err
  );

endinterface

// File: rtl/sram_wdog.sv
// Per-beat handshake watchdog: counts enabled cycles and flags when TMO is reached.
module sram_wdog
  import sram_burst_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Fires on the TMO-th enabled cycle so the owner can act in that same cycle.
  assign expired = en && (count_reg == CW'(TMO - 1));

endmodule

// File: rtl/sram_burst_master.sv
// Splits a 1..16 beat burst into single-beat SRAM controller commands with timeout.
module sram_burst_master
  import sram_burst_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_burst_master_if.master bus
);

  state_t            state_reg;
  logic              ctrl_start_reg;
  logic              ctrl_rw_reg;
  logic [AW-1:0]     ctrl_addr_reg;
  logic [DW-1:0]     ctrl_wdata_reg;
  logic [DW-1:0]     rd_data_reg;
  logic              rd_valid_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic [BEAT_W-1:0] beats_reg;

  logic              wd_en;
  logic              wd_clr;
  logic              wd_expired;
  logic              beat_adv;
  logic [BEAT_W-1:0] beats_left;

  // The timeout window opens at ISSUE, so an abandoned beat ends exactly TMO cycles after start.
  assign wd_en  = (state_reg == ISSUE) || (state_reg == WAIT_LO) || (state_reg == WAIT_HI);
  assign wd_clr = !wd_en;

  sram_wdog #(.TMO(TMO)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign beat_adv   = ((state_reg == WAIT_HI) && bus.ctrl_ready && ctrl_rw_reg) ||
                      ((state_reg == RD_OUT) && bus.rd_ready);
  assign beats_left = beats_reg - BEAT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ctrl_start_reg <= 1'b0;
      ctrl_rw_reg    <= 1'b0;
      ctrl_addr_reg  <= '0;
      ctrl_wdata_reg <= '0;
      rd_data_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      beats_reg      <= '0;
    end else begin
      ctrl_start_reg <= 1'b0;
      done_reg       <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            ctrl_rw_reg   <= bus.req_rw;
            ctrl_addr_reg <= bus.req_addr;
            beats_reg     <= beat_count(bus.req_len);
            err_reg       <= 1'b0;
            busy_reg      <= 1'b1;
            if (bus.req_rw) begin
              state_reg <= FETCH;
            end else begin
              state_reg      <= ISSUE;
              ctrl_start_reg <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (bus.wr_valid) begin
            ctrl_wdata_reg <= bus.wr_data;
            ctrl_start_reg <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: state_reg <= WAIT_LO;
        WAIT_LO: begin
          if (wd_expired) begin
            err_reg   <= 1'b1;
            beats_reg <= '0;
            done_reg  <= 1'b1;
            state_reg <= FIN;
          end else if (!bus.ctrl_ready) begin
            state_reg <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // A completing handshake wins over a simultaneous expiry.
          if (bus.ctrl_ready) begin
            if (!ctrl_rw_reg) begin
              rd_data_reg  <= bus.ctrl_rdata;
              rd_valid_reg <= 1'b1;
              state_reg    <= RD_OUT;
            end
          end else if (wd_expired) begin
            err_reg   <= 1'b1;
            beats_reg <= '0;
            done_reg  <= 1'b1;
            state_reg <= FIN;
          end
        end
        RD_OUT: begin
          if (bus.rd_ready) begin
            rd_valid_reg <= 1'b0;
          end
        end
        FIN: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (beat_adv) begin
        ctrl_addr_reg <= ctrl_addr_reg + AW'(1);
        beats_reg     <= beats_left;
        if (beats_left == '0) begin
          done_reg  <= 1'b1;
          state_reg <= FIN;
        end else if (ctrl_rw_reg) begin
          state_reg <= FETCH;
        end else begin
          ctrl_start_reg <= 1'b1;
          state_reg      <= ISSUE;
        end
      end
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.wr_ready   = (state_reg == FETCH);
  assign bus.ctrl_start = ctrl_start_reg;
  assign bus.ctrl_rw    = ctrl_rw_reg;
  assign bus.ctrl_addr  = ctrl_addr_reg;
  assign bus.ctrl_wdata = ctrl_wdata_reg;
  assign bus.rd_data    = rd_data_reg;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_sram_burst_master.sv
// Scenario bench for sram_burst_master against a behavioural SRAM controller model.
module tb_sram_burst_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_burst_master_if #(.AW(8), .DW(8)) bus ();

  sram_burst_master #(.AW(8), .DW(8), .TMO(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Controller model: ready stays high one cycle after start, then low for lat_cfg cycles.
  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;
  logic       m_busy, m_hold, m_rdy, m_rw;
  logic [7:0] m_addr, m_wd, m_rdata;
  int         m_low;
  int         lat_cfg  = 1;
  logic       stuck_hi = 1'b0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_hold  <= 1'b0;
      m_rdy   <= 1'b1;
      m_rdata <= 8'h00;
    end else if (!m_busy && bus.ctrl_start) begin
      m_busy <= 1'b1;
      m_hold <= 1'b1;
      m_rw   <= bus.ctrl_rw;
      m_addr <= bus.ctrl_addr;
      m_wd   <= bus.ctrl_wdata;
    end else if (m_hold) begin
      m_hold <= 1'b0;
      m_rdy  <= 1'b0;
      m_low  <= lat_cfg;
    end else if (m_busy) begin
      if (m_low <= 1) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
        if (m_rw) mem[m_addr] <= m_wd;
        else      m_rdata <= mem[m_addr];
      end else begin
        m_low <= m_low - 1;
      end
    end
  end

  assign bus.ctrl_ready = stuck_hi ? 1'b1 : m_rdy;
  assign bus.ctrl_rdata = m_rdata;

  // Monitor: logs each command and done pulse with the index of the cycle it was high in.
  int         cyc      = 0;
  int         done_cnt = 0;
  int         start_cyc_log[$];
  int         done_cyc_log[$];
  logic [7:0] start_addr_log[$];

  always @(posedge clk) begin
    if (bus.ctrl_start === 1'b1) begin
      start_addr_log.push_back(bus.ctrl_addr);
      start_cyc_log.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc_log.push_back(cyc);
    end
    cyc++;
  end

  logic [7:0]  exp_q[$];
  logic [15:0] wexp_q[$];

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic start_burst(input logic rw, input logic [7:0] a, input logic [3:0] len);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL req_ready_wait: got 0 required 1"); end
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = a; bus.req_len = len;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rd_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rd_valid === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rd_valid_wait: got 0 required 1"); end
  endtask

  task automatic wait_wr_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.wr_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wr_ready_wait: got 0 required 1"); end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL idle_wait: busy got 1 required 0"); end
  endtask

  task automatic feed_wr(input logic [7:0] a, input logic [7:0] d);
    bit ok;
    wait_wr_ready(ok);
    wexp_q.push_back({a, d});
    bus.wr_valid = 1'b1; bus.wr_data = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_beat(input string name);
    bit ok;
    logic [7:0] e;
    wait_rd_valid(ok);
    if (!ok || exp_q.size() == 0) return;
    e = exp_q.pop_front();
    vectors++;
    if (bus.rd_data !== e) begin
      miscompares++; $display("FAIL %s_data: got %h required %h", name, bus.rd_data, e);
    end
    bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.rd_ready = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL %s_valid_drop: got %b required 0", name, bus.rd_valid);
    end
    $display("read beat %s data %h", name, e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.req_ready, bus.wr_ready, bus.busy, bus.done, bus.err, bus.ctrl_start, bus.rd_valid} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 1000000",
               {bus.req_ready, bus.wr_ready, bus.busy, bus.done, bus.err, bus.ctrl_start, bus.rd_valid});
    end
    vectors++;
    if ({bus.ctrl_rw, bus.ctrl_addr, bus.ctrl_wdata, bus.rd_data} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {bus.ctrl_rw, bus.ctrl_addr, bus.ctrl_wdata, bus.rd_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_read_burst();
    int sb = start_addr_log.size();
    int d0 = done_cnt;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      preload(8'(8'h10 + i), 8'(8'hA0 + i));
      exp_q.push_back(8'(8'hA0 + i));
    end
    start_burst(1'b0, 8'h10, 4'd3);
    vectors++;
    if ({bus.busy, bus.req_ready} !== 2'b10) begin
      miscompares++; $display("FAIL rd_busy: got %b required 10", {bus.busy, bus.req_ready});
    end
    wait_rd_valid(ok);
    vectors++;
    if (start_cyc_log.size() <= sb || cyc - start_cyc_log[sb] != 4) begin
      miscompares++; $display("FAIL rd_latency: got %0d required 4",
                              (start_cyc_log.size() > sb) ? cyc - start_cyc_log[sb] : -1);
    end
    for (int b = 0; b < 4; b++) read_beat("rd_burst");
    wait_idle();
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL rd_done: got %0d required 1", done_cnt - d0);
    end
    vectors++;
    if (start_addr_log.size() - sb != 4) begin
      miscompares++; $display("FAIL rd_starts: got %0d required 4", start_addr_log.size() - sb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (start_addr_log[sb + i] !== 8'(8'h10 + i)) begin
          miscompares++; $display("FAIL rd_addr: got %h required %h", start_addr_log[sb + i], 8'(8'h10 + i));
        end
      end
    end
  endtask

  task automatic test_write_wrap();
    int sb = start_addr_log.size();
    logic [7:0] addrs [3];
    logic [7:0] data [3];
    logic [15:0] w;
    addrs[0] = 8'hFE; addrs[1] = 8'hFF; addrs[2] = 8'h00;
    data[0]  = 8'h11; data[1]  = 8'h22; data[2]  = 8'h33;
    start_burst(1'b1, 8'hFE, 4'd2);
    for (int b = 0; b < 3; b++) feed_wr(addrs[b], data[b]);
    wait_idle();
    while (wexp_q.size() > 0) begin
      w = wexp_q.pop_front();
      vectors++;
      if (mem[w[15:8]] !== w[7:0]) begin
        miscompares++; $display("FAIL wr_wrap_mem[%h]: got %h required %h", w[15:8], mem[w[15:8]], w[7:0]);
      end
      $display("write beat addr %h data %h", w[15:8], w[7:0]);
    end
    for (int b = 0; b < 3; b++) begin
      vectors++;
      if (start_addr_log.size() <= sb + b || start_addr_log[sb + b] !== addrs[b]) begin
        miscompares++; $display("FAIL wr_wrap_addr: beat %0d required %h", b, addrs[b]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s;
    int d0 = done_cnt;
    bit ok;
    preload(8'h40, 8'h5A);
    preload(8'h41, 8'h5B);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5B);
    start_burst(1'b0, 8'h40, 4'd1);
    wait_rd_valid(ok);
    s = start_addr_log.size();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h5A}) begin
        miscompares++; $display("FAIL bp_hold: got %b/%h required 1/5a", bus.rd_valid, bus.rd_data);
      end
      @(negedge clk);
    end
    vectors++;
    if (start_addr_log.size() != s) begin
      miscompares++; $display("FAIL bp_no_start: got %0d required %0d", start_addr_log.size(), s);
    end
    read_beat("bp");
    read_beat("bp");
    wait_idle();
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL bp_done: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_write_stall();
    int s;
    bit ok;
    logic [15:0] w;
    preload(8'h81, 8'hEE);
    start_burst(1'b1, 8'h80, 4'd1);
    feed_wr(8'h80, 8'hC1);
    wait_wr_ready(ok);
    s = start_addr_log.size();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({bus.wr_ready, mem[8'h81]} !== {1'b1, 8'hEE}) begin
        miscompares++; $display("FAIL stall_hold: got %b/%h required 1/ee", bus.wr_ready, mem[8'h81]);
      end
      @(negedge clk);
    end
    vectors++;
    if (start_addr_log.size() != s) begin
      miscompares++; $display("FAIL stall_no_start: got %0d required %0d", start_addr_log.size(), s);
    end
    feed_wr(8'h81, 8'hC2);
    wait_idle();
    while (wexp_q.size() > 0) begin
      w = wexp_q.pop_front();
      vectors++;
      if (mem[w[15:8]] !== w[7:0]) begin
        miscompares++; $display("FAIL stall_mem[%h]: got %h required %h", w[15:8], mem[w[15:8]], w[7:0]);
      end
      $display("write beat addr %h data %h", w[15:8], w[7:0]);
    end
  endtask

  task automatic test_timeout();
    int sb = start_addr_log.size();
    int d0 = done_cnt;
    int dl;
    stuck_hi = 1'b1;
    start_burst(1'b0, 8'h05, 4'd0);
    wait_idle();
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++; $display("FAIL tmo_err: got %b required 1", bus.err);
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL tmo_done: got %0d required 1", done_cnt - d0);
    end
    dl = (done_cyc_log.size() > 0 && start_cyc_log.size() > sb) ?
         done_cyc_log[done_cyc_log.size() - 1] - start_cyc_log[sb] : -1;
    vectors++;
    if (dl != 16) begin
      miscompares++; $display("FAIL tmo_delay: got %0d required 16", dl);
    end
    $display("timeout burst done after %0d cycles", dl);
    stuck_hi = 1'b0;
    preload(8'h06, 8'h77);
    exp_q.push_back(8'h77);
    start_burst(1'b0, 8'h06, 4'd0);
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++; $display("FAIL tmo_err_clear: got %b required 0", bus.err);
    end
    read_beat("after_tmo");
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int sb = start_addr_log.size();
    int d0;
    bit ok = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hA0 + i));
    lat_cfg = 4;
    start_burst(1'b0, 8'h10, 4'd3);
    read_beat("pre_rst");
    read_beat("pre_rst");
    for (int i = 0; i < 50; i++) begin
      if (start_addr_log.size() == sb + 3 && bus.ctrl_ready === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rst_mid_reach: got 0 required 1"); end
    @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ctrl_start, bus.ctrl_rw, bus.ctrl_addr, bus.ctrl_wdata, bus.rd_data,
         bus.rd_valid, bus.busy, bus.done, bus.err} !== 30'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got %h required 0",
               {bus.ctrl_start, bus.ctrl_rw, bus.ctrl_addr, bus.ctrl_wdata, bus.rd_data,
                bus.rd_valid, bus.busy, bus.done, bus.err});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt != d0 || start_addr_log.size() != sb + 3) begin
      miscompares++; $display("FAIL rst_mid_quiet: done %0d required %0d", done_cnt - d0, 0);
    end
    rst_n   = 1'b1;
    lat_cfg = 1;
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    d0 = done_cnt;
    start_burst(1'b0, 8'h12, 4'd1);
    read_beat("post_rst");
    read_beat("post_rst");
    wait_idle();
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL rst_mid_fresh_done: got %0d required 1", done_cnt - d0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = 8'h00; bus.req_len = 4'd0;
    bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b0;
    bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_burst();
    test_write_wrap();
    test_backpressure();
    test_write_stall();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end

endmodule
